// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bundle between the two requesters, the arbiter and the register file write port.
// master = requester/regfile side, slave = arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              req0_valid;
  logic [AW-1:0]     req0_addr;
  logic [DW-1:0]     req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [AW-1:0]     req1_addr;
  logic [DW-1:0]     req1_data;
  logic              req1_ready;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [2**AW-1:0]  pending;
  logic [CW-1:0]     q0_count;
  logic [CW-1:0]     q1_count;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, wr_en, wr_addr, wr_data, pending, q0_count, q1_count
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, wr_en, wr_addr, wr_data, pending, q0_count, q1_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter: two per-port FIFOs drained onto the regfile write port, 2 edges accept-to-commit.
// Backpressure: reqN_ready drops only while that FIFO holds DEPTH entries (state only, no valid/grant path).
module regfile_wb_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input logic                 clk,
  input logic                 Reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int NREG = 2 ** AW;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  wb_entry_t       mem    [2][DEPTH];
  logic [PW-1:0]   rd_ptr [2];
  logic [PW-1:0]   wr_ptr [2];
  logic [CW-1:0]   count  [2];
  wb_entry_t       push_dat [2];
  logic            last;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;

  logic [1:0]      acc;
  logic [1:0]      pop;
  logic [1:0]      nonempty;
  logic            grant_vld;
  logic            grant_port;
  wb_entry_t       head;
  logic [NREG-1:0] pend;
  logic [PW-1:0]   slot_off;

  assign push_dat[0] = '{addr: bus.req0_addr, data: bus.req0_data};
  assign push_dat[1] = '{addr: bus.req1_addr, data: bus.req1_data};

  assign bus.req0_ready = (count[0] < FULL);
  assign bus.req1_ready = (count[1] < FULL);
  assign acc[0] = bus.req0_valid && (count[0] < FULL);
  assign acc[1] = bus.req1_valid && (count[1] < FULL);

  // Under contention the port not served last wins; otherwise the only non-empty port wins.
  always_comb begin
    nonempty[0] = (count[0] != '0);
    nonempty[1] = (count[1] != '0);
    grant_vld   = |nonempty;
    grant_port  = (&nonempty) ? ~last : nonempty[1];
    pop         = '0;
    if (grant_vld) pop[grant_port] = 1'b1;
    head        = mem[grant_port][rd_ptr[grant_port]];
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (acc[p]) mem[p][wr_ptr[p]] <= push_dat[p];
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int p = 0; p < 2; p++) begin
        rd_ptr[p] <= '0;
        wr_ptr[p] <= '0;
        count[p]  <= '0;
      end
      last      <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p]) rd_ptr[p] <= rd_ptr[p] + 1'b1;
        count[p] <= count[p] + CW'(acc[p]) - CW'(pop[p]);
      end
      if (grant_vld) begin
        last      <= grant_port;
        wr_addr_q <= head.addr;
        wr_data_q <= head.data;
      end
      // Register 0 is hardwired: its writes drain through but never assert the enable.
      wr_en_q <= grant_vld && (head.addr != '0);
    end
  end

  always_comb begin
    pend     = '0;
    slot_off = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_off = PW'(i) - rd_ptr[p];
        if (CW'(slot_off) < count[p]) pend[mem[p][i].addr] = 1'b1;
      end
    end
    if (wr_en_q) pend[wr_addr_q] = 1'b1;
    pend[0] = 1'b0;
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.pending  = pend;
  assign bus.q0_count = count[0];
  assign bus.q1_count = count[1];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed cycle table, then queue-model checked sequences and random traffic.
module tb_regfile_wb_arbiter;
  localparam int DW = 32, AW = 5, DEPTH = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    bit v0; logic [4:0] a0; logic [31:0] d0;
    bit v1; logic [4:0] a1; logic [31:0] d1;
    bit e_en; logic [4:0] e_addr; logic [31:0] e_data; logic [31:0] e_pend;
    int e_c0; int e_c1; bit e_r0; bit e_r1;
  } vec_t;

  logic clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_arbiter_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) bus ();
  regfile_wb_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (.clk(clk), .Reset(Reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference model: plain queues, a round-robin flag and the write stage.
  ent_t mq0[$], mq1[$];
  bit            m_last;
  bit            m_en;
  logic [4:0]    m_addr;
  logic [31:0]   m_data;
  ent_t src0[$], src1[$], pushed0[$], pushed1[$], dut_log[$];
  vec_t tbl[20];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] pb(input int a);
    return 32'h1 << a;
  endfunction

  function automatic vec_t mk(bit v0, logic [4:0] a0, logic [31:0] d0, bit v1, logic [4:0] a1,
                              logic [31:0] d1, bit en, logic [4:0] ea, logic [31:0] ed,
                              logic [31:0] ep, int c0, int c1, bit r0, bit r1);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.e_en = en; v.e_addr = ea; v.e_data = ed; v.e_pend = ep;
    v.e_c0 = c0; v.e_c1 = c1; v.e_r0 = r0; v.e_r1 = r1;
    return v;
  endfunction

  function automatic void model_reset();
    mq0.delete(); mq1.delete();
    m_last = 1'b1; m_en = 1'b0; m_addr = '0; m_data = '0;
  endfunction

  function automatic void model_edge(bit v0, ent_t e0, bit v1, ent_t e1);
    bit   acc0, acc1;
    int   g;
    ent_t h;
    acc0 = v0 && (mq0.size() < DEPTH);
    acc1 = v1 && (mq1.size() < DEPTH);
    g = -1;
    if (mq0.size() > 0 && mq1.size() > 0) g = m_last ? 0 : 1;
    else if (mq0.size() > 0) g = 0;
    else if (mq1.size() > 0) g = 1;
    if (g >= 0) begin
      h = (g == 0) ? mq0.pop_front() : mq1.pop_front();
      m_en = (h.addr != 0); m_addr = h.addr; m_data = h.data; m_last = (g == 1);
    end else begin
      m_en = 1'b0;
    end
    if (acc0) mq0.push_back(e0);
    if (acc1) mq1.push_back(e1);
  endfunction

  function automatic void check_model(input string tag);
    logic [31:0] ep;
    ep = '0;
    foreach (mq0[i]) ep[mq0[i].addr] = 1'b1;
    foreach (mq1[i]) ep[mq1[i].addr] = 1'b1;
    if (m_en) ep[m_addr] = 1'b1;
    ep[0] = 1'b0;
    chk({tag, " wr_en"}, bus.wr_en, m_en);
    chk({tag, " wr_addr"}, bus.wr_addr, m_addr);
    chk({tag, " wr_data"}, bus.wr_data, m_data);
    chk({tag, " pending"}, bus.pending, ep);
    chk({tag, " q0_count"}, bus.q0_count, mq0.size());
    chk({tag, " q1_count"}, bus.q1_count, mq1.size());
    chk({tag, " req0_ready"}, bus.req0_ready, mq0.size() < DEPTH);
    chk({tag, " req1_ready"}, bus.req1_ready, mq1.size() < DEPTH);
  endfunction

  task automatic drive();
    bus.req0_valid = (src0.size() > 0);
    bus.req0_addr  = (src0.size() > 0) ? src0[0].addr : '0;
    bus.req0_data  = (src0.size() > 0) ? src0[0].data : '0;
    bus.req1_valid = (src1.size() > 0);
    bus.req1_addr  = (src1.size() > 0) ? src1[0].addr : '0;
    bus.req1_data  = (src1.size() > 0) ? src1[0].data : '0;
  endtask

  task automatic cycle(input string tag);
    bit a0, a1;
    drive();
    a0 = bus.req0_valid && bus.req0_ready;
    a1 = bus.req1_valid && bus.req1_ready;
    model_edge(bus.req0_valid, {bus.req0_addr, bus.req0_data}, bus.req1_valid, {bus.req1_addr, bus.req1_data});
    @(posedge clk); #1;
    if (a0) pushed0.push_back(src0.pop_front());
    if (a1) pushed1.push_back(src1.pop_front());
    if (bus.wr_en) dut_log.push_back({bus.wr_addr, bus.wr_data});
    check_model(tag);
  endtask

  task automatic do_reset();
    #2 Reset = 1'b1;
    #1 Reset = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " wr_en"}, bus.wr_en, 0);
    chk({tag, " wr_addr"}, bus.wr_addr, 0);
    chk({tag, " wr_data"}, bus.wr_data, 0);
    chk({tag, " pending"}, bus.pending, 0);
    chk({tag, " q0_count"}, bus.q0_count, 0);
    chk({tag, " q1_count"}, bus.q1_count, 0);
    chk({tag, " req0_ready"}, bus.req0_ready, 1);
    chk({tag, " req1_ready"}, bus.req1_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit saw_full;
    int n, post;
    ent_t it;

    // Contention (port 0 wins first after reset), same address, single write, address 0.
    tbl[0]  = mk(1, 1, 32'h101, 1, 11, 32'h20B, 0, 0, 0, pb(1) | pb(11), 1, 1, 1, 1);
    tbl[1]  = mk(1, 2, 32'h102, 1, 12, 32'h20C, 1, 1, 32'h101, pb(1) | pb(2) | pb(11) | pb(12), 1, 2, 1, 0);
    tbl[2]  = mk(1, 3, 32'h103, 1, 13, 32'h20D, 1, 11, 32'h20B, pb(11) | pb(2) | pb(3) | pb(12), 2, 1, 0, 1);
    tbl[3]  = mk(1, 4, 32'h104, 1, 13, 32'h20D, 1, 2, 32'h102, pb(2) | pb(3) | pb(12) | pb(13), 1, 2, 1, 0);
    tbl[4]  = mk(1, 4, 32'h104, 1, 14, 32'h20E, 1, 12, 32'h20C, pb(12) | pb(3) | pb(4) | pb(13), 2, 1, 0, 1);
    tbl[5]  = mk(0, 0, 0, 1, 14, 32'h20E, 1, 3, 32'h103, pb(3) | pb(4) | pb(13) | pb(14), 1, 2, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 13, 32'h20D, pb(13) | pb(4) | pb(14), 1, 1, 1, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 4, 32'h104, pb(4) | pb(14), 0, 1, 1, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 14, 32'h20E, pb(14), 0, 0, 1, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 14, 32'h20E, 0, 0, 0, 1, 1);
    tbl[10] = mk(1, 7, 32'hAAAA0007, 1, 7, 32'hBBBB0007, 0, 14, 32'h20E, pb(7), 1, 1, 1, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 7, 32'hAAAA0007, pb(7), 0, 1, 1, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 7, 32'hBBBB0007, pb(7), 0, 0, 1, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 7, 32'hBBBB0007, 0, 0, 0, 1, 1);
    tbl[14] = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 7, 32'hBBBB0007, pb(5), 1, 0, 1, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, pb(5), 0, 0, 1, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 0, 0, 0, 1, 1);
    tbl[17] = mk(0, 0, 0, 1, 0, 32'h1234, 0, 5, 32'hDEADBEEF, 0, 0, 1, 1, 1);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h1234, 0, 0, 0, 1, 1);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h1234, 0, 0, 0, 1, 1);

    Reset = 1'b1;
    src0.delete(); src1.delete();
    drive();
    #12;
    check_reset_vals("reset");
    Reset = 1'b0;
    model_reset();

    for (int i = 0; i < 20; i++) begin
      bus.req0_valid = tbl[i].v0; bus.req0_addr = tbl[i].a0; bus.req0_data = tbl[i].d0;
      bus.req1_valid = tbl[i].v1; bus.req1_addr = tbl[i].a1; bus.req1_data = tbl[i].d1;
      @(posedge clk); #1;
      chk($sformatf("row%0d wr_en", i), bus.wr_en, tbl[i].e_en);
      chk($sformatf("row%0d wr_addr", i), bus.wr_addr, tbl[i].e_addr);
      chk($sformatf("row%0d wr_data", i), bus.wr_data, tbl[i].e_data);
      chk($sformatf("row%0d pending", i), bus.pending, tbl[i].e_pend);
      chk($sformatf("row%0d q0_count", i), bus.q0_count, tbl[i].e_c0);
      chk($sformatf("row%0d q1_count", i), bus.q1_count, tbl[i].e_c1);
      chk($sformatf("row%0d req0_ready", i), bus.req0_ready, tbl[i].e_r0);
      chk($sformatf("row%0d req1_ready", i), bus.req1_ready, tbl[i].e_r1);
    end

    // Full FIFO: port 1 keeps contending so port 0 backs up and must hold its next request.
    do_reset();
    dut_log.delete(); pushed0.delete(); pushed1.delete();
    for (int i = 0; i < 4; i++) begin
      src0.push_back({5'(20 + i), 32'h3000 + i});
      src1.push_back({5'(24 + i), 32'h4000 + i});
    end
    saw_full = 1'b0;
    for (int c = 0; c < 40 && (src0.size() + src1.size() + mq0.size() + mq1.size() > 0 || m_en); c++) begin
      cycle("full");
      if (bus.q0_count == 2'(DEPTH) && !bus.req0_ready && bus.req0_valid) saw_full = 1'b1;
    end
    chk("full held request seen", saw_full, 1);
    chk("full drained", src0.size() + src1.size(), 0);
    for (int i = 0; i < 4; i++) begin
      it = {5'(20 + i), 32'h3000 + i};
      n = 0;
      foreach (dut_log[k]) if (dut_log[k] == it) n++;
      chk($sformatf("full commit once p0 #%0d", i), n, 1);
      it = {5'(24 + i), 32'h4000 + i};
      n = 0;
      foreach (dut_log[k]) if (dut_log[k] == it) n++;
      chk($sformatf("full commit once p1 #%0d", i), n, 1);
    end

    // Random traffic, requesters hold each request until accepted.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (src0.size() == 0 && $urandom_range(0, 3) != 0) src0.push_back({5'($urandom_range(0, 31)), 32'($urandom)});
      if (src1.size() == 0 && $urandom_range(0, 3) != 0) src1.push_back({5'($urandom_range(0, 31)), 32'($urandom)});
      cycle("rand");
    end
    for (int c = 0; c < 20 && (src0.size() + src1.size() + mq0.size() + mq1.size() > 0 || m_en); c++) cycle("rand drain");
    chk("rand drained", src0.size() + src1.size(), 0);

    // Asynchronous reset while entries are queued and a write is on the port.
    do_reset();
    src0.push_back({5'd3, 32'h5003}); src0.push_back({5'd4, 32'h5004}); src0.push_back({5'd6, 32'h5006});
    src1.push_back({5'd8, 32'h5008}); src1.push_back({5'd9, 32'h5009});
    cycle("midrst pre");
    cycle("midrst pre");
    #2 Reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    src0.delete(); src1.delete();
    drive();
    @(posedge clk); #3;
    Reset = 1'b0;
    model_reset();
    post = 0;
    for (int c = 0; c < 6; c++) begin
      cycle("after reset");
      if (bus.wr_en) post++;
    end
    chk("no write after reset", post, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
